// File: rtl/enemy_pool_if.sv
// enemy_pool_if: frame, spawn, Mario, per-slot collision and draw signals of the enemy pool
interface enemy_pool_if #(parameter int N_SLOTS = 4);
  localparam int SW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  logic frame_clk, kill_all, Shift;
  logic spawn_valid, spawn_ready;
  logic [9:0] spawn_x, spawn_y, Mario_X, Mario_Y, DrawX, DrawY;
  logic [3*N_SLOTS-1:0] poll_left, poll_right, poll_down;
  logic [N_SLOTS-1:0] alive;
  logic [10*N_SLOTS-1:0] enemy_x, enemy_y;
  logic stomp_pulse, kill_Mario, draw_is_enemy, draw_squish, draw_frame;
  logic [2:0] stomp_count;
  logic [SW-1:0] draw_slot;
  modport master (
    output frame_clk, kill_all, Shift, spawn_valid, spawn_x, spawn_y, Mario_X, Mario_Y,
           DrawX, DrawY, poll_left, poll_right, poll_down,
    input  spawn_ready, alive, enemy_x, enemy_y, stomp_pulse, stomp_count, kill_Mario,
           draw_is_enemy, draw_slot, draw_squish, draw_frame
  );
  modport slave (
    input  frame_clk, kill_all, Shift, spawn_valid, spawn_x, spawn_y, Mario_X, Mario_Y,
           DrawX, DrawY, poll_left, poll_right, poll_down,
    output spawn_ready, alive, enemy_x, enemy_y, stomp_pulse, stomp_count, kill_Mario,
           draw_is_enemy, draw_slot, draw_squish, draw_frame
  );
endinterface

// File: rtl/enemy_pool.sv
// enemy_pool: slot-based walking-enemy manager (spawn, walk, fall, stomp, squish, draw hit test)
module enemy_pool #(
  parameter int N_SLOTS = 4, X_SIZE = 20, Y_SIZE = 20, X_MIN = 120, X_MAX = 519, Y_MAX = 439,
  parameter int WALK_STEP = 1, FALL_MAX = 4, SHIFT_PX = 40, STOMP_WIN = 8, SQUISH_FR = 30,
  parameter int ANIM_FR = 16
) (
  input logic Clk,
  input logic Reset,
  enemy_pool_if.slave bus
);
  localparam int SW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  localparam int SPW = $clog2(FALL_MAX + 1);
  localparam int AW = ANIM_FR > 1 ? $clog2(ANIM_FR) : 1;
  localparam int TW = $clog2(SQUISH_FR + 1);
  typedef enum logic [1:0] {FREE, WALK, FALL, SQUISH} st_t;
  logic r_fclk_d, r_tick, r_pulse, r_kill, w_clr;
  logic [2:0] r_cnt, w_cnt;
  logic [N_SLOTS-1:0] w_free, w_take, w_stomp, w_side, w_hit, w_sq, w_fr;
  logic [9:0] w_mb, w_mt, w_shift;
  assign w_clr = Reset | bus.kill_all;
  assign w_mb = bus.Mario_Y + 10'd20;
  assign w_mt = bus.Mario_Y - 10'd20;
  assign w_shift = bus.Shift ? 10'(SHIFT_PX) : 10'd0;
  // isolate the lowest FREE slot; empty when the pool is full
  assign w_take = bus.spawn_valid ? w_free & (~w_free + N_SLOTS'(1)) : '0;
  assign bus.spawn_ready = |w_free;
  assign bus.stomp_pulse = r_pulse;
  assign bus.stomp_count = r_cnt;
  assign bus.kill_Mario = r_kill;
  assign bus.draw_is_enemy = |w_hit;
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) w_cnt = w_cnt + 3'(w_stomp[i]);
  end
  always_comb begin
    bus.draw_slot = '0;
    bus.draw_squish = 1'b0;
    bus.draw_frame = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        bus.draw_slot = SW'(i);
        bus.draw_squish = w_sq[i];
        bus.draw_frame = w_fr[i];
      end
    end
  end
  always_ff @(posedge Clk) begin
    r_fclk_d <= Reset ? 1'b0 : bus.frame_clk;
    r_tick <= w_clr ? 1'b0 : bus.frame_clk & ~r_fclk_d;
    r_pulse <= ~w_clr & r_tick & |w_stomp;
    r_cnt <= (~w_clr & r_tick) ? w_cnt : 3'd0;
    r_kill <= ~w_clr & (r_kill | (r_tick & |w_side));
  end
  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    st_t r_st;
    logic [9:0] r_x, r_y, w_dx, w_top, w_nx;
    logic r_dir, r_frame, w_alive, w_ovl, w_gone, w_gnd, w_ndir, w_wrap;
    logic [SPW-1:0] r_spd;
    logic [AW-1:0] r_anim;
    logic [TW-1:0] r_tmr;
    assign w_alive = r_st == WALK || r_st == FALL;
    assign w_dx = bus.Mario_X >= r_x ? bus.Mario_X - r_x : r_x - bus.Mario_X;
    assign w_top = r_y - 10'(Y_SIZE);
    assign w_ovl = w_alive && w_dx < 10'(X_SIZE + 20);
    assign w_stomp[s] = w_ovl && w_mb >= w_top && w_mb < w_top + 10'(STOMP_WIN);
    assign w_side[s] = w_ovl && !w_stomp[s] && w_mb >= w_top + 10'(STOMP_WIN) && w_mt < r_y + 10'(Y_SIZE);
    assign w_gone = r_x + 10'(X_SIZE) < 10'(X_MIN) || w_top > 10'(Y_MAX);
    assign w_gnd = |bus.poll_down[3*s +: 3];
    assign w_ndir = |bus.poll_left[3*s +: 3] ? 1'b1 :
                    (|bus.poll_right[3*s +: 3] || r_x + 10'(X_SIZE) >= 10'(X_MAX)) ? 1'b0 : r_dir;
    assign w_nx = (w_ndir ? r_x + 10'(WALK_STEP) : r_x - 10'(WALK_STEP)) - w_shift;
    assign w_wrap = r_anim == AW'(ANIM_FR - 1);
    assign w_free[s] = r_st == FREE;
    assign w_sq[s] = r_st == SQUISH;
    assign w_fr[s] = r_frame;
    assign w_hit[s] = !w_free[s] && bus.DrawX >= r_x - 10'(X_SIZE) && bus.DrawX < r_x + 10'(X_SIZE) &&
                      bus.DrawY >= w_top && bus.DrawY < r_y + 10'(Y_SIZE);
    assign bus.alive[s] = w_alive;
    assign bus.enemy_x[10*s +: 10] = r_x;
    assign bus.enemy_y[10*s +: 10] = r_y;
    always_ff @(posedge Clk) begin
      if (w_clr) begin
        r_st <= FREE;
        r_x <= '0;
        r_y <= '0;
        r_dir <= 1'b0;
        r_spd <= '0;
        r_anim <= '0;
        r_frame <= 1'b0;
        r_tmr <= '0;
      end else if (w_take[s]) begin
        r_st <= FALL;
        r_x <= bus.spawn_x;
        r_y <= bus.spawn_y - 10'(Y_SIZE);
        r_dir <= 1'b0;
        r_spd <= '0;
        r_anim <= '0;
        r_frame <= 1'b0;
      end else if (r_tick) begin
        if (r_st == SQUISH) begin
          r_x <= r_x - w_shift;
          r_tmr <= r_tmr - TW'(1);
          r_st <= r_tmr == TW'(1) ? FREE : SQUISH;
        end else if (w_stomp[s]) begin
          r_st <= SQUISH;
          r_tmr <= TW'(SQUISH_FR);
        end else if (w_alive && !w_side[s]) begin
          if (w_gone) r_st <= FREE;
          else begin
            r_dir <= w_ndir;
            r_x <= w_nx;
            r_st <= w_gnd ? WALK : FALL;
            r_y <= w_gnd ? r_y : r_y + 10'(r_spd);
            r_spd <= w_gnd ? '0 : r_spd >= SPW'(FALL_MAX) ? SPW'(FALL_MAX) : r_spd + SPW'(1);
            r_anim <= w_wrap ? '0 : r_anim + AW'(1);
            r_frame <= r_frame ^ w_wrap;
          end
        end
      end
    end
  end
endmodule
